// File: rtl/acl_txbuf_ctrl_if.sv
// Host/baseband-facing signal bundle for the ACL transmit double-buffer controller.
// The master side drives commits, flushes, and TX strobes; the slave side is the controller.
interface acl_txbuf_ctrl_if #(
    parameter int LEN_W = 10
);
    logic             connsnew;
    logic [2:0]       ms_lt_addr;
    logic [7:0]       dec_arqn;
    logic             header_st_p;
    logic             regi_txwr_p;
    logic [LEN_W-1:0] regi_txlen;
    logic             regi_flushcmd_p;
    logic             wr_ptr;
    logic             txbuf_rdsel;
    logic [LEN_W-1:0] txpylen;
    logic             send_new_p;
    logic             send_old_p;
    logic             send_0c_p;
    logic             send_null_p;
    logic             txbuf_full;
    logic             txbuf_empty;
    logic             txbuf_ovf;

    modport master (
        output connsnew, ms_lt_addr, dec_arqn, header_st_p,
        output regi_txwr_p, regi_txlen, regi_flushcmd_p,
        input  wr_ptr, txbuf_rdsel, txpylen,
        input  send_new_p, send_old_p, send_0c_p, send_null_p,
        input  txbuf_full, txbuf_empty, txbuf_ovf
    );

    modport slave (
        input  connsnew, ms_lt_addr, dec_arqn, header_st_p,
        input  regi_txwr_p, regi_txlen, regi_flushcmd_p,
        output wr_ptr, txbuf_rdsel, txpylen,
        output send_new_p, send_old_p, send_0c_p, send_null_p,
        output txbuf_full, txbuf_empty, txbuf_ovf
    );
endinterface

// File: rtl/acl_txbuf_ctrl.sv
// ACL transmit double-buffer controller: host commits, ARQN-driven new/old/null/0c payload decisions.
// Optional flush support is enabled by defining ACLTXBUF_FLUSH_EN.
module acl_txbuf_ctrl #(
    parameter int LEN_W = 10
) (
    input  logic                clk_6M,
    input  logic                rstz,
    acl_txbuf_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        BUF_EMPTY    = 2'd0,
        BUF_FILLED   = 2'd1,
        BUF_INFLIGHT = 2'd2
    } buf_st_e;

    buf_st_e          st_q [2];
    buf_st_e          st_d [2];
    logic [LEN_W-1:0] len_q [2];
    logic [LEN_W-1:0] len_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             rdsel_q, rdsel_d;
    logic [LEN_W-1:0] txpylen_q, txpylen_d;
    logic             new_q, new_d;
    logic             old_q, old_d;
    logic             oc_q, oc_d;
    logic             null_q, null_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             ack_s;
    logic             inflight_s;
    logic             nxt_s;
`ifdef ACLTXBUF_FLUSH_EN
    logic             flush_pend_q, flush_pend_d;
`else
    logic             unused_flush_s;
    assign unused_flush_s = bus.regi_flushcmd_p;
`endif

    assign ack_s      = bus.dec_arqn[bus.ms_lt_addr];
    // The in-flight buffer, when there is one, is always the one rd_ptr points at.
    assign inflight_s = (st_q[rd_ptr_q] == BUF_INFLIGHT);
    assign nxt_s      = ~rd_ptr_q;

    // Next-state: header decision and host commit both evaluated on the pre-edge buffer state.
    always_comb begin
        st_d      = st_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rdsel_d   = rdsel_q;
        txpylen_d = txpylen_q;
        new_d     = 1'b0;
        old_d     = 1'b0;
        oc_d      = 1'b0;
        null_d    = 1'b0;
        ovf_d     = ovf_q;
`ifdef ACLTXBUF_FLUSH_EN
        flush_pend_d = flush_pend_q;
`endif

        if (bus.header_st_p) begin
            if (inflight_s && !ack_s) begin
`ifdef ACLTXBUF_FLUSH_EN
                if (flush_pend_q) begin
                    st_d[rd_ptr_q] = BUF_EMPTY;
                    rd_ptr_d       = nxt_s;
                    oc_d           = 1'b1;
                    txpylen_d      = {LEN_W{1'b0}};
                end else begin
                    old_d     = 1'b1;
                    txpylen_d = len_q[rd_ptr_q];
                end
`else
                old_d     = 1'b1;
                txpylen_d = len_q[rd_ptr_q];
`endif
            end else if (inflight_s) begin
                st_d[rd_ptr_q] = BUF_EMPTY;
                rd_ptr_d       = nxt_s;
                if (st_q[nxt_s] == BUF_FILLED) begin
                    st_d[nxt_s] = BUF_INFLIGHT;
                    rdsel_d     = nxt_s;
                    txpylen_d   = len_q[nxt_s];
                    new_d       = 1'b1;
                end else begin
                    null_d    = 1'b1;
                    txpylen_d = {LEN_W{1'b0}};
                end
            end else if (st_q[rd_ptr_q] == BUF_FILLED) begin
                st_d[rd_ptr_q] = BUF_INFLIGHT;
                rdsel_d        = rd_ptr_q;
                txpylen_d      = len_q[rd_ptr_q];
                new_d          = 1'b1;
            end else begin
                null_d    = 1'b1;
                txpylen_d = {LEN_W{1'b0}};
            end
`ifdef ACLTXBUF_FLUSH_EN
            flush_pend_d = 1'b0;
`endif
        end else begin
            rdsel_d = rdsel_q;
        end

`ifdef ACLTXBUF_FLUSH_EN
        // A flush request arriving with a header is kept for the following decision.
        if (bus.regi_flushcmd_p) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_d;
        end
`endif

        // A buffer released by this header is still non-EMPTY pre-edge, so a same-cycle commit is dropped.
        if (bus.regi_txwr_p) begin
            if (st_q[wr_ptr_q] == BUF_EMPTY) begin
                st_d[wr_ptr_q]  = BUF_FILLED;
                len_d[wr_ptr_q] = bus.regi_txlen;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = ovf_d;
        end

        full_d  = (st_d[0] != BUF_EMPTY) && (st_d[1] != BUF_EMPTY);
        empty_d = (st_d[0] == BUF_EMPTY) && (st_d[1] == BUF_EMPTY);

        if (bus.connsnew) begin
            st_d[0]   = BUF_EMPTY;
            st_d[1]   = BUF_EMPTY;
            len_d[0]  = {LEN_W{1'b0}};
            len_d[1]  = {LEN_W{1'b0}};
            wr_ptr_d  = 1'b0;
            rd_ptr_d  = 1'b0;
            rdsel_d   = 1'b0;
            txpylen_d = {LEN_W{1'b0}};
            new_d     = 1'b0;
            old_d     = 1'b0;
            oc_d      = 1'b0;
            null_d    = 1'b0;
            ovf_d     = 1'b0;
            full_d    = 1'b0;
            empty_d   = 1'b1;
`ifdef ACLTXBUF_FLUSH_EN
            flush_pend_d = 1'b0;
`endif
        end else begin
            full_d = full_d;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            st_q[0]   <= BUF_EMPTY;
            st_q[1]   <= BUF_EMPTY;
            len_q[0]  <= {LEN_W{1'b0}};
            len_q[1]  <= {LEN_W{1'b0}};
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rdsel_q   <= 1'b0;
            txpylen_q <= {LEN_W{1'b0}};
            new_q     <= 1'b0;
            old_q     <= 1'b0;
            oc_q      <= 1'b0;
            null_q    <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
`ifdef ACLTXBUF_FLUSH_EN
            flush_pend_q <= 1'b0;
`endif
        end else begin
            st_q      <= st_d;
            len_q     <= len_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rdsel_q   <= rdsel_d;
            txpylen_q <= txpylen_d;
            new_q     <= new_d;
            old_q     <= old_d;
            oc_q      <= oc_d;
            null_q    <= null_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
`ifdef ACLTXBUF_FLUSH_EN
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.txbuf_rdsel = rdsel_q;
    assign bus.txpylen     = txpylen_q;
    assign bus.send_new_p  = new_q;
    assign bus.send_old_p  = old_q;
    assign bus.send_0c_p   = oc_q;
    assign bus.send_null_p = null_q;
    assign bus.txbuf_full  = full_q;
    assign bus.txbuf_empty = empty_q;
    assign bus.txbuf_ovf   = ovf_q;
endmodule

// File: tb/tb_acl_txbuf_ctrl.sv
// Directed self-checking bench for acl_txbuf_ctrl; pulse vector is {new, old, 0c, null}.
module tb_acl_txbuf_ctrl;
    localparam int LEN_W = 10;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    acl_txbuf_ctrl_if #(.LEN_W(LEN_W)) bus ();

    acl_txbuf_ctrl #(.LEN_W(LEN_W)) dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic cyc();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.send_new_p, bus.send_old_p, bus.send_0c_p, bus.send_null_p};
    endfunction

    task automatic do_reset();
        rstz = 1'b0;
        cyc();
        rstz = 1'b1;
    endtask

    task automatic commit(input int len);
        bus.regi_txwr_p = 1'b1;
        bus.regi_txlen  = LEN_W'(len);
        cyc();
        bus.regi_txwr_p = 1'b0;
    endtask

    // Only bit ms_lt_addr=3 carries the ack; the other bits are the inverse to catch wrong indexing.
    task automatic header(input logic ack);
        bus.dec_arqn    = ack ? 8'b0000_1000 : 8'b1111_0111;
        bus.header_st_p = 1'b1;
        cyc();
        bus.header_st_p = 1'b0;
    endtask

    task automatic chk_dec(input string tag, input logic [3:0] p, input int len, input logic sel);
        chk({tag, "_pulse"}, {28'd0, pulses()}, {28'd0, p});
        chk({tag, "_len"}, {22'd0, bus.txpylen}, len);
        chk({tag, "_rdsel"}, {31'd0, bus.txbuf_rdsel}, {31'd0, sel});
    endtask

    initial begin
        bus.connsnew        = 1'b0;
        bus.ms_lt_addr      = 3'd3;
        bus.dec_arqn        = 8'd0;
        bus.header_st_p     = 1'b0;
        bus.regi_txwr_p     = 1'b0;
        bus.regi_txlen      = '0;
        bus.regi_flushcmd_p = 1'b0;
        #2;
        do_reset();

        // Reset state
        chk("rst_wr", {31'd0, bus.wr_ptr}, 32'd0);
        chk_dec("rst", 4'b0000, 0, 1'b0);
        chk("rst_empty", {31'd0, bus.txbuf_empty}, 32'd1);
        chk("rst_full", {31'd0, bus.txbuf_full}, 32'd0);
        chk("rst_ovf", {31'd0, bus.txbuf_ovf}, 32'd0);

        // First transmission of a fresh payload
        commit(27);
        chk("c27_wr", {31'd0, bus.wr_ptr}, 32'd1);
        chk("c27_empty", {31'd0, bus.txbuf_empty}, 32'd0);
        header(1'b1);
        chk_dec("new27", 4'b1000, 27, 1'b0);
        chk("new27_empty", {31'd0, bus.txbuf_empty}, 32'd0);
        cyc();
        chk("new27_oneshot", {28'd0, pulses()}, 32'd0);
        chk("new27_hold", {22'd0, bus.txpylen}, 32'd27);

        // NAKs retransmit the in-flight payload
        for (int i = 0; i < 3; i++) begin
            header(1'b0);
            chk_dec("old27", 4'b0100, 27, 1'b0);
            chk("old27_wr", {31'd0, bus.wr_ptr}, 32'd1);
        end

        // Flush of an in-flight payload on NAK
        do_reset();
        commit(17);
        header(1'b1);
        chk_dec("new17", 4'b1000, 17, 1'b0);
        bus.regi_flushcmd_p = 1'b1;
        cyc();
        bus.regi_flushcmd_p = 1'b0;
        header(1'b0);
`ifdef ACLTXBUF_FLUSH_EN
        chk_dec("flush0c", 4'b0010, 0, 1'b0);
        chk("flush_empty", {31'd0, bus.txbuf_empty}, 32'd1);
`else
        chk_dec("flush_old", 4'b0100, 17, 1'b0);
        chk("flush_empty", {31'd0, bus.txbuf_empty}, 32'd0);
`endif

        // Overflow and in-order drain
        do_reset();
        commit(10);
        commit(20);
        chk("full2", {31'd0, bus.txbuf_full}, 32'd1);
        chk("ovf_before", {31'd0, bus.txbuf_ovf}, 32'd0);
        commit(30);
        chk("ovf_after", {31'd0, bus.txbuf_ovf}, 32'd1);
        chk("ovf_wr", {31'd0, bus.wr_ptr}, 32'd0);
        header(1'b1);
        chk_dec("drain10", 4'b1000, 10, 1'b0);
        header(1'b1);
        chk_dec("drain20", 4'b1000, 20, 1'b1);
        header(1'b1);
        chk_dec("drain_null", 4'b0001, 0, 1'b1);
        chk("drain_empty", {31'd0, bus.txbuf_empty}, 32'd1);
        chk("drain_ovf_sticky", {31'd0, bus.txbuf_ovf}, 32'd1);

        // Commit colliding with the release of the same buffer
        do_reset();
        commit(5);
        header(1'b1);
        chk_dec("col_new5", 4'b1000, 5, 1'b0);
        commit(6);
        chk("col_wr0", {31'd0, bus.wr_ptr}, 32'd0);
        bus.regi_txwr_p = 1'b1;
        bus.regi_txlen  = 10'd7;
        header(1'b1);
        bus.regi_txwr_p = 1'b0;
        chk_dec("col_new6", 4'b1000, 6, 1'b1);
        chk("col_ovf", {31'd0, bus.txbuf_ovf}, 32'd1);
        chk("col_wr_kept", {31'd0, bus.wr_ptr}, 32'd0);
        commit(7);
        chk("col_retry_wr", {31'd0, bus.wr_ptr}, 32'd1);
        chk("col_retry_full", {31'd0, bus.txbuf_full}, 32'd1);
        header(1'b1);
        chk_dec("col_new7", 4'b1000, 7, 1'b0);

        // Connection setup while buffer1 in flight and buffer0 filled
        do_reset();
        commit(1);
        header(1'b1);
        commit(2);
        header(1'b1);
        chk_dec("cn_new2", 4'b1000, 2, 1'b1);
        commit(3);
        commit(4);
        chk("cn_ovf_set", {31'd0, bus.txbuf_ovf}, 32'd1);
        bus.connsnew = 1'b1;
        cyc();
        bus.connsnew = 1'b0;
        chk("cn_wr", {31'd0, bus.wr_ptr}, 32'd0);
        chk_dec("cn_rst", 4'b0000, 0, 1'b0);
        chk("cn_empty", {31'd0, bus.txbuf_empty}, 32'd1);
        chk("cn_full", {31'd0, bus.txbuf_full}, 32'd0);
        chk("cn_ovf", {31'd0, bus.txbuf_ovf}, 32'd0);
        header(1'b1);
        chk_dec("cn_null", 4'b0001, 0, 1'b0);

        // Zero-length commit is a normal payload
        commit(0);
        chk("z_wr", {31'd0, bus.wr_ptr}, 32'd1);
        chk("z_empty", {31'd0, bus.txbuf_empty}, 32'd0);
        header(1'b1);
        chk_dec("z_new", 4'b1000, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
